// File: rtl/fp_pkg.sv
// Shared FP definitions: default field widths, field offsets and class codes.
// Used by the FIFO word reader and by the FP arithmetic units.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // Operand layout is {sign, exp, man}, with the mantissa starting at bit 0.
  localparam int MAN_LSB = 0;

  function automatic int exp_lsb(input int man_w);
    return man_w;
  endfunction

  function automatic int sign_pos(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction

  typedef enum logic [2:0] {
    FP_CLS_NORM   = 3'd0,
    FP_CLS_ZERO   = 3'd1,
    FP_CLS_DENORM = 3'd2,
    FP_CLS_INF    = 3'd3,
    FP_CLS_NAN    = 3'd4
  } fp_class_e;

endpackage

// File: rtl/fp_classify.sv
// Purpose: classifies an operand magnitude {exp, man} as zero/denorm/inf/NaN.
// Latency: purely combinational.
// Backpressure: none; this block holds no state.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W+MAN_W-1:0] mag,
  output logic                   is_zero,
  output logic                   is_inf,
  output logic                   is_nan,
  output logic                   is_denorm
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  fp_class_e        cls;

  // The sign bit does not affect the class, so only the magnitude comes in.
  assign exp_f = mag[exp_lsb(MAN_W) +: EXP_W];
  assign man_f = mag[MAN_LSB +: MAN_W];

  always_comb begin
    cls = FP_CLS_NORM;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? FP_CLS_ZERO : FP_CLS_DENORM;
    end else if (&exp_f) begin
      cls = (man_f == '0) ? FP_CLS_INF : FP_CLS_NAN;
    end
  end

  assign is_zero   = (cls == FP_CLS_ZERO);
  assign is_denorm = (cls == FP_CLS_DENORM);
  assign is_inf    = (cls == FP_CLS_INF);
  assign is_nan    = (cls == FP_CLS_NAN);

endmodule

// File: rtl/fifo_word_reader.sv
// Purpose: pops DSIZE-bit FIFO beats and assembles them little-endian into one FP operand.
// Latency: operand valid the cycle after its final beat is popped; one operand per NBEATS cycles.
// Backpressure: a held output stalls only the final beat; earlier beats keep popping.
module fifo_word_reader
  import fp_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int WSIZE = 1 + EXP_W + MAN_W
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rd,
  input  logic             flush,
  output logic [WSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_zero,
  output logic             out_is_inf,
  output logic             out_is_nan,
  output logic             out_is_denorm,
  output logic             partial
);

  localparam int NBEATS = WSIZE / DSIZE;
  localparam int CW     = (NBEATS > 2) ? $clog2(NBEATS) : 1;
  localparam int PW     = (NBEATS - 1) * DSIZE;
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  logic [CW-1:0] cnt;
  logic [PW-1:0] pbuf;
  logic          last_beat;

  assign last_beat = (cnt == LAST);

  // The final beat may only be taken when the output register is free or being drained.
  assign rd = rrst_n & ~rempty & ~flush & (~last_beat | ~out_valid | out_ready);

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      cnt       <= '0;
      pbuf      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (flush) begin
        cnt  <= '0;
        pbuf <= '0;
      end else if (rd) begin
        if (last_beat) begin
          out_data <= {rdata, pbuf};
          cnt      <= '0;
        end else begin
          pbuf[cnt*DSIZE +: DSIZE] <= rdata;
          cnt                      <= cnt + CW'(1);
        end
      end

      // A final-beat pop reloads the register even while the old operand is accepted.
      if (rd && last_beat) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign partial = (cnt != '0);

  fp_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_classify (
    .mag      (out_data[sign_pos(EXP_W, MAN_W)-1:0]),
    .is_zero  (out_is_zero),
    .is_inf   (out_is_inf),
    .is_nan   (out_is_nan),
    .is_denorm(out_is_denorm)
  );

endmodule

// File: tb/tb_fifo_word_reader.sv
// Bench for fifo_word_reader: FWFT FIFO model, byte-collecting reference model and
// an output scoreboard drained by an independent monitor.
module tb_fifo_word_reader;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rd;
  logic        flush;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_zero, out_is_inf, out_is_nan, out_is_denorm;
  logic        partial;

  fifo_word_reader dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .rdata        (rdata),
    .rempty       (rempty),
    .rd           (rd),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_is_zero  (out_is_zero),
    .out_is_inf   (out_is_inf),
    .out_is_nan   (out_is_nan),
    .out_is_denorm(out_is_denorm),
    .partial      (partial)
  );

  always #5 rclk = ~rclk;

  logic [7:0]  fifo_q[$];
  logic [7:0]  pending[$];
  logic [31:0] exp_q[$];
  bit          stall;
  int          pops;
  int          checks;
  int          passes;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Class flags {zero, inf, nan, denorm} straight from the IEEE-754 field rules.
  function automatic logic [3:0] cls_of(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] m;
    e = w[30:23];
    m = w[22:0];
    return {(e == 8'h00) && (m == 0), (e == 8'hFF) && (m == 0),
            (e == 8'hFF) && (m != 0), (e == 8'h00) && (m != 0)};
  endfunction

  task automatic drive_fifo();
    rempty = stall || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) fifo_q.push_back(w[8*i +: 8]);
    drive_fifo();
  endtask

  // One clock: sample the pop decision before the edge, then update the models after it.
  task automatic cycle();
    logic rd_s, fl_s, rst_s, emp_s;
    logic [31:0] w;
    #1;
    rd_s  = rd;
    fl_s  = flush;
    rst_s = rrst_n;
    emp_s = rempty;
    if (!rst_s) check(rd === 1'b0, "rd_in_reset", {31'd0, rd}, 32'd0);
    if (fl_s)   check(rd === 1'b0, "rd_in_flush", {31'd0, rd}, 32'd0);
    @(posedge rclk);
    #1;
    if (rd_s === 1'b1) begin
      if (emp_s || fifo_q.size() == 0) begin
        check(1'b0, "pop_while_empty", 32'd1, 32'd0);
      end else begin
        pending.push_back(fifo_q.pop_front());
        pops++;
        if (pending.size() == 4) begin
          w = {pending[3], pending[2], pending[1], pending[0]};
          exp_q.push_back(w);
          pending.delete();
        end
      end
    end
    if (!rst_s) begin
      pending.delete();
      exp_q.delete();
    end else if (fl_s) begin
      pending.delete();
    end
    drive_fifo();
    check(partial === (pending.size() != 0), "partial", {31'd0, partial},
          {31'd0, pending.size() != 0});
  endtask

  always @(negedge rclk) begin : monitor
    logic [31:0] w;
    if (rrst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_operand", out_data, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check(out_data === w, "operand", out_data, w);
        check({out_is_zero, out_is_inf, out_is_nan, out_is_denorm} === cls_of(w), "class",
              {28'd0, out_is_zero, out_is_inf, out_is_nan, out_is_denorm}, {28'd0, cls_of(w)});
      end
    end
  end

  logic [31:0] cls_words[4] = '{32'h7F800000, 32'h7FC00001, 32'h00000001, 32'h80000000};

  initial begin
    logic [31:0] wa, wb, wc;
    int base;
    checks = 0; passes = 0; pops = 0;
    rrst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; stall = 1'b0;
    drive_fifo();
    repeat (2) cycle();
    check(out_valid === 1'b0, "reset_valid", {31'd0, out_valid}, 32'd0);
    check(out_data === 32'd0, "reset_data", out_data, 32'd0);
    check({out_is_zero, out_is_inf, out_is_nan, out_is_denorm} === 4'b1000, "reset_class",
          {28'd0, out_is_zero, out_is_inf, out_is_nan, out_is_denorm}, 32'h8);
    rrst_n = 1'b1;

    // 1.0: four beats, one-cycle valid pulse with ready high
    out_ready = 1'b1;
    base = pops;
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h80); push_byte(8'h3F);
    repeat (4) cycle();
    check(pops - base == 4, "pops_one", pops - base, 4);
    check(out_valid === 1'b1, "one_valid", {31'd0, out_valid}, 32'd1);
    check(out_data === 32'h3F800000, "one_data", out_data, 32'h3F800000);
    cycle();
    check(out_valid === 1'b0, "one_valid_drop", {31'd0, out_valid}, 32'd0);

    // class corners
    foreach (cls_words[i]) begin
      push_word(cls_words[i]);
      repeat (5) cycle();
    end

    // backpressure: second operand waits on its final beat
    out_ready = 1'b0;
    wa = $urandom; wb = $urandom;
    base = pops;
    push_word(wa); push_word(wb);
    repeat (10) cycle();
    check(pops - base == 7, "bp_pops", pops - base, 7);
    check(rd === 1'b0, "bp_rd_stall", {31'd0, rd}, 32'd0);
    check(partial === 1'b1, "bp_partial", {31'd0, partial}, 32'd1);
    check(out_valid === 1'b1 && out_data === wa, "bp_hold", out_data, wa);
    out_ready = 1'b1;
    cycle();
    check(out_valid === 1'b1, "bp_reload_valid", {31'd0, out_valid}, 32'd1);
    check(out_data === wb, "bp_reload_data", out_data, wb);
    check(pops - base == 8, "bp_pops_final", pops - base, 8);
    cycle();
    check(out_valid === 1'b0, "bp_drained", {31'd0, out_valid}, 32'd0);

    // flush after two beats
    push_byte(8'hAA); push_byte(8'h55);
    repeat (3) cycle();
    wc = $urandom;
    push_word(wc);
    flush = 1'b1;
    base = pops;
    cycle();
    flush = 1'b0;
    check(pops == base, "flush_no_pop", pops - base, 0);
    check(partial === 1'b0, "flush_partial", {31'd0, partial}, 32'd0);
    repeat (5) cycle();

    // reset mid-operand
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    repeat (4) cycle();
    push_word($urandom);
    rrst_n = 1'b0;
    cycle();
    rrst_n = 1'b1;
    check(out_valid === 1'b0, "rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check(partial === 1'b0, "rst_mid_partial", {31'd0, partial}, 32'd0);
    repeat (5) cycle();

    // empty stall with two beats held
    push_byte(8'hC3); push_byte(8'h3C);
    repeat (3) cycle();
    stall = 1'b1;
    push_byte(8'h5A); push_byte(8'hA5);
    repeat (10) begin
      cycle();
      check(rd === 1'b0 && partial === 1'b1, "stall_hold", {30'd0, rd, partial}, 32'd1);
    end
    stall = 1'b0;
    drive_fifo();
    repeat (5) cycle();

    // random traffic, biased toward class-corner byte values
    repeat (600) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      stall     = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: push_byte(8'h00);
          1: push_byte(8'hFF);
          2: push_byte(8'h7F);
          3: push_byte(8'h80);
          default: push_byte(8'($urandom));
        endcase
      end
      drive_fifo();
      cycle();
    end
    flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
    drive_fifo();
    for (int i = 0; i < 300 && (fifo_q.size() != 0 || exp_q.size() != 0); i++) cycle();
    check(fifo_q.size() == 0 && exp_q.size() == 0, "drain",
          fifo_q.size() + exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
